// File: rtl/clockworks_pkg.sv
// Shared defaults and helpers for the clockworks clock-generation block.
package clockworks_pkg;

    localparam int CLOCKWORKS_SLOW_DEFAULT         = 0;
    localparam int CLOCKWORKS_RESET_CYCLES_DEFAULT = 16;

    // Period of clock_out in clock_in cycles for a given divider exponent.
    function automatic int unsigned clockworks_period(input int unsigned slow);
        return 32'd1 << (slow + 1);
    endfunction

endpackage

// File: rtl/clockworks_reset_stretch.sv
// Holds the downstream reset low for RESET_CYCLES ticks after reset release.
module clockworks_reset_stretch
    import clockworks_pkg::*;
#(
    parameter int RESET_CYCLES = CLOCKWORKS_RESET_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    output logic resetn_o
);

    localparam int CW = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (rst_i) begin
            cnt_d = CW'(RESET_CYCLES);
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign resetn_o = (cnt_q == '0);

endmodule

// File: rtl/clockworks.sv
// Power-of-two clock divider with tick strobe and downstream active-low reset.
// Optional reset stretching is enabled with CLOCKWORKS_RESET_STRETCH_EN.
module clockworks
    import clockworks_pkg::*;
#(
    parameter int SLOW         = CLOCKWORKS_SLOW_DEFAULT,
    parameter int RESET_CYCLES = CLOCKWORKS_RESET_CYCLES_DEFAULT
) (
    input  logic clock_in,
    input  logic reset,
    output logic clock_out,
    output logic tick,
    output logic resetn_out
);

    generate
        if (SLOW > 0) begin : g_div
            // Power-up value lets simulation divide even without a reset.
            logic [SLOW:0] count_q = '0;
            logic [SLOW:0] count_d;

            always_comb begin
                count_d = reset ? '0 : count_q + 1'b1;
            end

            always_ff @(posedge clock_in) begin
                count_q <= count_d;
            end

            // Straight from a flop so the core clock cannot glitch.
            assign clock_out = count_q[SLOW];
            assign tick      = !reset && !count_q[SLOW] && (&count_q[SLOW-1:0]);
        end else begin : g_pass
            assign clock_out = clock_in;
            assign tick      = !reset;
        end
    endgenerate

`ifdef CLOCKWORKS_RESET_STRETCH_EN
    clockworks_reset_stretch #(
        .RESET_CYCLES(RESET_CYCLES)
    ) u_stretch (
        .clk_i   (clock_in),
        .rst_i   (reset),
        .tick_i  (tick),
        .resetn_o(resetn_out)
    );
`else
    logic resetn_q;
    logic resetn_d;

    assign resetn_d = !reset;

    always_ff @(posedge clock_in) begin
        resetn_q <= resetn_d;
    end

    assign resetn_out = resetn_q;
`endif

endmodule

// File: tb/tb_clockworks.sv
// Randomized bench for clockworks: four dividers checked against an edge-count model.
module tb_clockworks;
    import clockworks_pkg::*;

    localparam int NI = 4;
    localparam int SL [NI] = '{0, 2, 3, 1};
    localparam int RC [NI] = '{16, 16, 16, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic co [NI];
    logic tk [NI];
    logic rn [NI];

    int tests  = 0;
    int failed = 0;

    // Model: edges since the last reset edge, and ticks seen since then.
    int unsigned n  [NI];
    int unsigned tc [NI];
    logic        rst_at_edge;

    always #5 clk = ~clk;

    clockworks #(.SLOW(SL[0]), .RESET_CYCLES(RC[0])) u_s0 (
        .clock_in(clk), .reset(rst), .clock_out(co[0]), .tick(tk[0]), .resetn_out(rn[0]));
    clockworks #(.SLOW(SL[1]), .RESET_CYCLES(RC[1])) u_s2 (
        .clock_in(clk), .reset(rst), .clock_out(co[1]), .tick(tk[1]), .resetn_out(rn[1]));
    clockworks #(.SLOW(SL[2]), .RESET_CYCLES(RC[2])) u_s3 (
        .clock_in(clk), .reset(rst), .clock_out(co[2]), .tick(tk[2]), .resetn_out(rn[2]));
    clockworks #(.SLOW(SL[3]), .RESET_CYCLES(RC[3])) u_s1 (
        .clock_in(clk), .reset(rst), .clock_out(co[3]), .tick(tk[3]), .resetn_out(rn[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_clk(input int unsigned cnt, input int slow);
        int unsigned p = clockworks_period(slow);
        return (cnt % p) >= (p / 2);
    endfunction

    function automatic logic exp_tick(input int unsigned cnt, input int slow, input logic r);
        int unsigned p = clockworks_period(slow);
        if (r) return 1'b0;
        if (slow == 0) return 1'b1;
        return (cnt % p) == (p / 2 - 1);
    endfunction

    // One clock_in cycle: drive reset after the falling edge, check after the rising edge.
    task automatic cycle(input logic r);
        logic tick_pre [NI];
        @(negedge clk);
        #1;
        check("s0_clk_low", co[0], 1'b0);
        rst = r;
        @(posedge clk);
        rst_at_edge = rst;
        for (int i = 0; i < NI; i++) tick_pre[i] = exp_tick(n[i], SL[i], rst_at_edge);
        for (int i = 0; i < NI; i++) begin
            if (rst_at_edge) begin
                n[i]  = 0;
                tc[i] = 0;
            end else begin
                n[i] = n[i] + 1;
                if (tick_pre[i]) tc[i] = tc[i] + 1;
            end
        end
        #1;
        check("s0_clk_high", co[0], 1'b1);
        for (int i = 1; i < NI; i++)
            check($sformatf("clk_out_s%0d", SL[i]), co[i], exp_clk(n[i], SL[i]));
        for (int i = 0; i < NI; i++)
            check($sformatf("tick_s%0d", SL[i]), tk[i], exp_tick(n[i], SL[i], rst));
        for (int i = 0; i < NI; i++) begin
`ifdef CLOCKWORKS_RESET_STRETCH_EN
            check($sformatf("resetn_s%0d", SL[i]), rn[i],
                  (!rst_at_edge && tc[i] >= RC[i]) ? 1'b1 : 1'b0);
`else
            check($sformatf("resetn_s%0d", SL[i]), rn[i], !rst_at_edge);
`endif
        end
    endtask

    initial begin
        int ticks;
        int rises;
        logic prev;
        bit found;

        for (int i = 0; i < NI; i++) begin
            n[i]  = 0;
            tc[i] = 0;
        end

        // Reset held three cycles, then run through several periods.
        for (int i = 0; i < 3; i++) cycle(1'b1);
        check("rst_clk_s2", co[1], 1'b0);
        check("rst_tick_s2", tk[1], 1'b0);
        check("rst_resetn_s2", rn[1], 1'b0);
        for (int i = 0; i < 24; i++) cycle(1'b0);

        // Free-run 64 cycles from reset on SLOW=3: four ticks, four rising edges.
        cycle(1'b1);
        ticks = 0;
        rises = 0;
        prev  = co[2];
        for (int i = 0; i < 64; i++) begin
            cycle(1'b0);
            if (tk[2]) ticks++;
            if (co[2] && !prev) rises++;
            prev = co[2];
        end
        check("s3_tick_count", ticks, 4);
        check("s3_rise_count", rises, 4);

        // Reset while SLOW=2 clock_out is high (counter at 5).
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if ((n[1] % 8) == 5) found = 1'b1;
            else cycle(1'b0);
        end
        check("s2_reach_cnt5", found, 1'b1);
        check("s2_high_before_rst", co[1], 1'b1);
        cycle(1'b1);
        check("s2_clk_after_rst", co[1], 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0);

        // Reassert reset after the second post-release tick on the SLOW=1 instance.
        cycle(1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0);
            if (tc[3] == 2) found = 1'b1;
        end
        check("s1_reach_tick2", found, 1'b1);
        cycle(1'b1);
        for (int i = 0; i < 24; i++) cycle(1'b0);

        // Random reset pulses over a long run.
        for (int i = 0; i < 600; i++) cycle(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
